// File: rtl/sub_serial.sv
// Bit-serial subtractor: diff = A - B - bin (mod 2^WIDTH), one bit per clock, LSB first.
// A start/busy/done engine with all outputs registered.
// Optional feature: define SUB_SERIAL_OVF_EN to add the signed-overflow output ovf.
module sub_serial #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SUB_SERIAL_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             br_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             busy_q;
  logic             done_q;
`ifdef SUB_SERIAL_OVF_EN
  logic             ovf_q;
`endif

  logic a_bit;
  logic b_bit;
  logic d_bit;
  logic br_d;
  logic last_bit;

  // One-bit full subtractor on the bit selected by the counter.
  always_comb begin
    a_bit    = a_q[cnt_q];
    b_bit    = b_q[cnt_q];
    d_bit    = a_bit ^ b_bit ^ br_q;
    br_d     = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);
    last_bit = (cnt_q == CW'(WIDTH - 1));
  end

  // Control FSM and datapath registers; DONE accepts a new start like IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SUB_SERIAL_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle, StDone: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= A;
            b_q     <= B;
            br_q    <= bin;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
`ifdef SUB_SERIAL_OVF_EN
            ovf_q   <= 1'b0;
`endif
            busy_q  <= 1'b1;
            state_q <= StRun;
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          diff_q[cnt_q] <= d_bit;
          br_q          <= br_d;
          cnt_q         <= cnt_q + 1'b1;
          if (last_bit) begin
            bout_q  <= br_d;
`ifdef SUB_SERIAL_OVF_EN
            // d_bit is the MSB of the difference on the final step.
            ovf_q   <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (d_bit != a_q[WIDTH-1]);
`endif
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
`ifdef SUB_SERIAL_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_sub_serial.sv
// Scoreboard bench for sub_serial (WIDTH=4): stimulus pushes expected results and the
// cycle at which done must appear; a monitor pops and compares on every done pulse.
module tb_sub_serial;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SUB_SERIAL_OVF_EN
  logic         ovf;
`endif

  typedef struct {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
    int           cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  sub_serial #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .A    (A),
    .B    (B),
    .bin  (bin),
    .busy (busy),
    .done (done),
    .diff (diff),
    .bout (bout)
`ifdef SUB_SERIAL_OVF_EN
    ,
    .ovf  (ovf)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1, expected no pulse (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("done_cycle", cyc, e.cyc);
        check("diff", int'(diff), int'(e.diff));
        check("bout", int'(bout), int'(e.bout));
        check("busy_at_done", int'(busy), 0);
`ifdef SUB_SERIAL_OVF_EN
        check("ovf", int'(ovf), int'(e.ovf));
`endif
      end
    end
  end

  // Present an operation at the current negedge; start becomes 'keep' after acceptance.
  // Returns at the negedge where done is expected.
  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                    input logic [W-1:0] ed, input logic eb, input logic eo, input logic keep);
    exp_t e;
    A     = a;
    B     = b;
    bin   = bi;
    start = 1'b1;
    e.diff = ed;
    e.bout = eb;
    e.ovf  = eo;
    e.cyc  = cyc + 1 + W;
    exp_q.push_back(e);
    @(negedge clk);
    start = keep;
    repeat (W) @(negedge clk);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    A     = '0;
    B     = '0;
    bin   = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_diff", int'(diff), 0);
    check("rst_bout", int'(bout), 0);
`ifdef SUB_SERIAL_OVF_EN
    check("rst_ovf", int'(ovf), 0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // Basic operations, idle gaps between some, back-to-back between others.
    op(4'b0101, 4'b0011, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    op(4'b0011, 4'b0101, 1'b0, 4'b1110, 1'b1, 1'b0, 1'b0);
    op(4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    op(4'b1000, 4'b0001, 1'b0, 4'b0111, 1'b0, 1'b1, 1'b0);
    op(4'b0111, 4'b1000, 1'b0, 4'b1111, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check("idle_busy", int'(busy), 0);
    check("idle_diff_hold", int'(diff), 4'b1111);

    // start held high across three operations.
    op(4'b0101, 4'b0011, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b1);
    op(4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
    op(4'b0000, 4'b0001, 1'b0, 4'b1111, 1'b1, 1'b0, 1'b0);
    @(negedge clk);

    // Inputs and start changing mid-RUN must be ignored.
    begin
      exp_t e;
      A     = 4'b1111;
      B     = 4'b0000;
      bin   = 1'b0;
      start = 1'b1;
      e.diff = 4'b1111;
      e.bout = 1'b0;
      e.ovf  = 1'b0;
      e.cyc  = cyc + 1 + W;
      exp_q.push_back(e);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      A     = 4'b0000;
      B     = 4'b1111;
      bin   = 1'b1;
      start = 1'b1;
      check("run_busy", int'(busy), 1);
      @(negedge clk);
      start = 1'b0;
      repeat (W) @(negedge clk);
    end

    // Reset mid-RUN aborts with no done pulse.
    A     = 4'b0110;
    B     = 4'b0001;
    bin   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_diff", int'(diff), 0);
    check("abort_bout", int'(bout), 0);
    repeat (W + 3) @(negedge clk);

    // Start coincident with reset is discarded.
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    check("rst_start_busy", int'(busy), 0);
    @(negedge clk);

    op(4'b0110, 4'b0001, 1'b0, 4'b0101, 1'b0, 1'b0, 1'b0);
    @(negedge clk);

    // Bounded drain: anything left in the queue is a missing done.
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
